// File: rtl/zap_btb_feedback_pkg.sv
// Shared types for the branch resolution / BTB feedback path: predictor state
// encodings, branch outcome classes and the feedback record sent to the BTB.
package zap_btb_feedback_pkg;

  // Same 2-bit encoding the BTB uses for its saturating direction state.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } t_br_state;

  typedef enum logic [1:0] {
    NO_FB        = 2'b00,
    OK           = 2'b01,
    OK_REDIRECT  = 2'b10,
    NOK_REDIRECT = 2'b11
  } t_outcome;

  typedef enum logic {
    IDLE   = 1'b0,
    SHADOW = 1'b1
  } t_fsm;

  typedef struct packed {
    logic [31:0] src;
    t_br_state   state;
    logic [31:0] dest;
    logic        ok;
    logic        nok;
  } t_fb;

  function automatic logic is_redirect(input t_outcome oc);
    return (oc == OK_REDIRECT) || (oc == NOK_REDIRECT);
  endfunction

endpackage

// File: rtl/zap_sat_counter.sv
// Saturating event counter: counts enabled increments and sticks at all-ones.
module zap_sat_counter
  import zap_btb_feedback_pkg::*;
#(
  parameter int CNT_WDT = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_inc,
  input  logic               i_stall,
  output logic [CNT_WDT-1:0] o_count
);

  logic [CNT_WDT-1:0] count_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else if (i_inc && !i_stall && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/zap_btb_feedback.sv
// Branch resolution unit: classifies resolved branches against the carried
// prediction, pulses BTB feedback, redirects fetch and masks the wrong path.
module zap_btb_feedback
  import zap_btb_feedback_pkg::*;
#(
  parameter int SHADOW_CYCLES = 3,
  parameter int CNT_WDT       = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_stall,
  input  logic               i_clear,
  input  logic               i_valid,
  input  logic [31:0]        i_pc,
  input  logic               i_btb_hit,
  input  logic [1:0]         i_pred_state,
  input  logic [31:0]        i_pred_target,
  input  logic               i_actual_taken,
  input  logic [31:0]        i_actual_target,
  output logic               o_fb_ok,
  output logic               o_fb_nok,
  output logic [31:0]        o_fb_branch_src_address,
  output logic [1:0]         o_fb_current_branch_state,
  output logic [31:0]        o_fb_branch_dest_address,
  output logic               o_clear_from_fb,
  output logic [31:0]        o_pc_from_fb,
  output logic [CNT_WDT-1:0] o_br_count,
  output logic [CNT_WDT-1:0] o_mispred_count
);

  localparam int SH_W = (SHADOW_CYCLES < 2) ? 1 : $clog2(SHADOW_CYCLES + 1);

  function automatic t_outcome classify(input logic hit, input logic [1:0] pstate,
                                        input logic taken, input logic [31:0] ptgt,
                                        input logic [31:0] atgt);
    logic pred_taken;
    pred_taken = hit && ((pstate == WT) || (pstate == ST));
    if (!hit)                   return taken ? NOK_REDIRECT : NO_FB;
    if (pred_taken != taken)    return NOK_REDIRECT;
    if (taken && (ptgt != atgt)) return OK_REDIRECT;
    return OK;
  endfunction

  t_fsm            state_q, state_d;
  logic [SH_W-1:0] shadow_q, shadow_d;
  t_fb             fb_q, fb_d;
  logic            clear_q, clear_d;
  logic [31:0]     pc_q, pc_d;
  logic            accept;
  logic            redirect;
  t_outcome        outcome;
  logic [31:0]     src_addr;

  assign src_addr = i_pc & ~32'd1;
  assign outcome  = classify(i_btb_hit, i_pred_state, i_actual_taken, i_pred_target,
                             i_actual_target);
  assign accept   = i_valid && !i_stall && !i_clear && (state_q == IDLE);
  assign redirect = accept && is_redirect(outcome);

  always_comb begin
    fb_d    = '0;
    clear_d = 1'b0;
    pc_d    = pc_q;
    if (accept && (outcome != NO_FB)) begin
      fb_d.src   = src_addr;
      fb_d.dest  = i_actual_target;
      fb_d.state = t_br_state'(i_pred_state);
      case (outcome)
        OK: fb_d.ok = 1'b1;
        OK_REDIRECT: begin
          fb_d.ok = 1'b1;
          clear_d = 1'b1;
          pc_d    = i_actual_target;
        end
        default: begin
          fb_d.nok = 1'b1;
          clear_d  = 1'b1;
          // A taken miss enters the BTB as weakly-not-taken; its update step makes it WT.
          if (!i_btb_hit) fb_d.state = WNT;
          pc_d = i_actual_taken ? i_actual_target : (src_addr + 32'd4);
        end
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    if (i_clear) begin
      state_d  = IDLE;
      shadow_d = '0;
    end else if (!i_stall) begin
      case (state_q)
        IDLE: begin
          if (redirect && (SHADOW_CYCLES > 0)) begin
            state_d  = SHADOW;
            shadow_d = SH_W'(SHADOW_CYCLES);
          end
        end
        default: begin
          shadow_d = shadow_q - 1'b1;
          if (shadow_q == SH_W'(1)) state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      fb_q     <= '0;
      clear_q  <= 1'b0;
      pc_q     <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      fb_q     <= fb_d;
      clear_q  <= clear_d;
      pc_q     <= pc_d;
    end
  end

  zap_sat_counter #(.CNT_WDT(CNT_WDT)) u_br_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (accept),
    .i_stall (i_stall),
    .o_count (o_br_count)
  );

  zap_sat_counter #(.CNT_WDT(CNT_WDT)) u_mispred_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (redirect),
    .i_stall (i_stall),
    .o_count (o_mispred_count)
  );

  assign o_fb_ok                   = fb_q.ok;
  assign o_fb_nok                  = fb_q.nok;
  assign o_fb_branch_src_address   = fb_q.src;
  assign o_fb_current_branch_state = fb_q.state;
  assign o_fb_branch_dest_address  = fb_q.dest;
  assign o_clear_from_fb           = clear_q;
  assign o_pc_from_fb              = pc_q;

endmodule

// File: tb/tb_zap_btb_feedback.sv
// Directed bench for zap_btb_feedback: a spec-level model checked every cycle
// against a full-width and a 4-bit-counter instance, plus literal spot checks.
module tb_zap_btb_feedback;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1, i_stall = 1'b0, i_clear = 1'b0, i_valid = 1'b0;
  logic [31:0] i_pc = '0, i_pred_target = '0, i_actual_target = '0;
  logic        i_btb_hit = 1'b0, i_actual_taken = 1'b0;
  logic [1:0]  i_pred_state = '0;

  logic        ok_a, nok_a, clr_a, ok_b, nok_b, clr_b;
  logic [31:0] src_a, dest_a, pc_a, brc_a, mpc_a, src_b, dest_b, pc_b;
  logic [1:0]  st_a, st_b;
  logic [3:0]  brc_b, mpc_b;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  zap_btb_feedback #(.SHADOW_CYCLES(3), .CNT_WDT(32)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_stall(i_stall), .i_clear(i_clear), .i_valid(i_valid),
    .i_pc(i_pc), .i_btb_hit(i_btb_hit), .i_pred_state(i_pred_state),
    .i_pred_target(i_pred_target), .i_actual_taken(i_actual_taken),
    .i_actual_target(i_actual_target), .o_fb_ok(ok_a), .o_fb_nok(nok_a),
    .o_fb_branch_src_address(src_a), .o_fb_current_branch_state(st_a),
    .o_fb_branch_dest_address(dest_a), .o_clear_from_fb(clr_a), .o_pc_from_fb(pc_a),
    .o_br_count(brc_a), .o_mispred_count(mpc_a)
  );

  zap_btb_feedback #(.SHADOW_CYCLES(3), .CNT_WDT(4)) dut4 (
    .i_clk(clk), .i_reset(i_reset), .i_stall(i_stall), .i_clear(i_clear), .i_valid(i_valid),
    .i_pc(i_pc), .i_btb_hit(i_btb_hit), .i_pred_state(i_pred_state),
    .i_pred_target(i_pred_target), .i_actual_taken(i_actual_taken),
    .i_actual_target(i_actual_target), .o_fb_ok(ok_b), .o_fb_nok(nok_b),
    .o_fb_branch_src_address(src_b), .o_fb_current_branch_state(st_b),
    .o_fb_branch_dest_address(dest_b), .o_clear_from_fb(clr_b), .o_pc_from_fb(pc_b),
    .o_br_count(brc_b), .o_mispred_count(mpc_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: expected outputs after each edge, from the classification rules.
  logic        m_ok, m_nok, m_clr;
  logic [31:0] m_src, m_dest, m_pc;
  logic [1:0]  m_st;
  int          m_shadow;
  longint      m_br, m_mp;

  always @(posedge clk) begin
    logic pt;
    logic [31:0] src;
    m_ok = 0; m_nok = 0; m_clr = 0; m_src = 0; m_dest = 0; m_st = 0;
    if (i_reset) begin
      m_pc = 0; m_shadow = 0; m_br = 0; m_mp = 0;
    end else if (i_clear) begin
      m_shadow = 0;
    end else if (i_valid && !i_stall && m_shadow == 0) begin
      m_br++;
      src = i_pc & 32'hFFFF_FFFE;
      pt = i_btb_hit && (i_pred_state >= 2);
      if (!i_btb_hit && !i_actual_taken) begin
        // no feedback at all
      end else begin
        m_src = src; m_dest = i_actual_target; m_st = i_pred_state;
        if (!i_btb_hit) begin
          m_nok = 1; m_st = 2'b01; m_clr = 1; m_pc = i_actual_target;
        end else if (pt != i_actual_taken) begin
          m_nok = 1; m_clr = 1;
          m_pc = i_actual_taken ? i_actual_target : src + 32'd4;
        end else if (i_actual_taken && i_pred_target != i_actual_target) begin
          m_ok = 1; m_clr = 1; m_pc = i_actual_target;
        end else begin
          m_ok = 1;
        end
      end
      if (m_clr) begin
        m_mp++;
        m_shadow = 3;
      end
    end else if (!i_stall && m_shadow > 0) begin
      m_shadow--;
    end
    #1;
    chk("fb_ok", ok_a, m_ok);         chk("fb_ok_w4", ok_b, m_ok);
    chk("fb_nok", nok_a, m_nok);      chk("fb_nok_w4", nok_b, m_nok);
    chk("src", src_a, m_src);         chk("src_w4", src_b, m_src);
    chk("state", st_a, m_st);         chk("state_w4", st_b, m_st);
    chk("dest", dest_a, m_dest);      chk("dest_w4", dest_b, m_dest);
    chk("clear", clr_a, m_clr);       chk("clear_w4", clr_b, m_clr);
    chk("pc_fb", pc_a, m_pc);         chk("pc_fb_w4", pc_b, m_pc);
    chk("br_count", brc_a, 32'(m_br > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : m_br));
    chk("mp_count", mpc_a, 32'(m_mp > 64'hFFFF_FFFF ? 64'hFFFF_FFFF : m_mp));
    chk("br_count_w4", 32'(brc_b), 32'(m_br > 15 ? 15 : m_br));
    chk("mp_count_w4", 32'(mpc_b), 32'(m_mp > 15 ? 15 : m_mp));
  end

  // Presents one branch for a single edge; returns at the following negedge.
  task automatic br(input logic hit, input logic [1:0] st, input logic [31:0] pc,
                    input logic [31:0] ptgt, input logic tk, input logic [31:0] atgt);
    @(negedge clk);
    i_valid = 1; i_btb_hit = hit; i_pred_state = st; i_pc = pc;
    i_pred_target = ptgt; i_actual_taken = tk; i_actual_target = atgt;
    @(negedge clk);
    i_valid = 0;
    $display("txn pc=%h hit=%0b st=%0d tk=%0b -> ok=%0b nok=%0b clr=%0b pc_fb=%h",
             pc, hit, st, tk, ok_a, nok_a, clr_a, pc_a);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int pulses;
    repeat (3) @(negedge clk);
    i_reset = 0;
    chk("rst_ok", ok_a, 0); chk("rst_clear", clr_a, 0); chk("rst_pc", pc_a, 0);
    chk("rst_br", brc_a, 0);

    br(1, 2'b11, 32'h40, 32'h100, 1, 32'h100);
    chk("t1_ok", ok_a, 1); chk("t1_src", src_a, 32'h40); chk("t1_st", st_a, 2'b11);
    chk("t1_dest", dest_a, 32'h100); chk("t1_clr", clr_a, 0); chk("t1_br", brc_a, 1);

    br(1, 2'b10, 32'h80, 32'h0, 0, 32'h1234);
    chk("t2_nok", nok_a, 1); chk("t2_st", st_a, 2'b10); chk("t2_clr", clr_a, 1);
    chk("t2_pc", pc_a, 32'h84);
    i_valid = 1; i_btb_hit = 1; i_pred_state = 2'b11; i_pc = 32'h90;
    i_pred_target = 32'hA0; i_actual_taken = 1; i_actual_target = 32'hA0;
    idle(3);
    chk("t2_shadow_quiet", ok_a, 0);
    idle(1);
    i_valid = 0;
    chk("t2_fourth_ok", ok_a, 1); chk("t2_fourth_src", src_a, 32'h90);
    chk("t2_mp", mpc_a, 1);

    br(0, 2'b00, 32'h100, 32'h0, 1, 32'h200);
    chk("t3_nok", nok_a, 1); chk("t3_st", st_a, 2'b01); chk("t3_pc", pc_a, 32'h200);
    idle(4);
    br(0, 2'b01, 32'h104, 32'h0, 0, 32'h999);
    chk("t3_miss_nt_quiet", {ok_a, nok_a, clr_a}, 3'b000);

    br(1, 2'b11, 32'h2F0, 32'h300, 1, 32'h304);
    chk("t4_ok", ok_a, 1); chk("t4_dest", dest_a, 32'h304); chk("t4_clr", clr_a, 1);
    chk("t4_pc", pc_a, 32'h304);
    idle(4);

    pulses = 0;
    @(negedge clk);
    i_valid = 1; i_stall = 1; i_btb_hit = 1; i_pred_state = 2'b11; i_pc = 32'h700;
    i_pred_target = 32'h710; i_actual_taken = 1; i_actual_target = 32'h710;
    repeat (4) begin @(negedge clk); pulses += int'(ok_a); end
    i_stall = 0;
    @(negedge clk); pulses += int'(ok_a);
    i_valid = 0;
    @(negedge clk); pulses += int'(ok_a);
    chk("t5_one_pulse", pulses, 1);

    br(1, 2'b10, 32'h500, 32'h0, 0, 32'h0);
    @(negedge clk); i_clear = 1;
    @(negedge clk); i_clear = 0;
    i_valid = 1; i_btb_hit = 1; i_pred_state = 2'b01; i_pc = 32'h600;
    i_actual_taken = 0; i_actual_target = 32'h0;
    @(negedge clk); i_valid = 0;
    chk("t6_after_clear_ok", ok_a, 1); chk("t6_src", src_a, 32'h600);

    br(1, 2'b11, 32'hFFFF_FFFC, 32'h0, 0, 32'h0);
    chk("t7_wrap_nok", nok_a, 1); chk("t7_wrap_pc", pc_a, 32'h0);

    br(1, 2'b11, 32'h800, 32'h0, 0, 32'h0);
    @(negedge clk); i_reset = 1;
    @(negedge clk); i_reset = 0;
    i_valid = 1; i_btb_hit = 1; i_pred_state = 2'b00; i_pc = 32'h900;
    i_actual_taken = 0;
    @(negedge clk); i_valid = 0;
    chk("t8_rst_ok", ok_a, 1); chk("t8_rst_src", src_a, 32'h900);
    chk("t8_rst_br", brc_a, 1); chk("t8_rst_mp", mpc_a, 0);

    for (int k = 0; k < 20; k++) begin
      br(0, 2'b00, 32'h1000 + 32'(k * 8), 32'h0, 1, 32'h2000 + 32'(k * 4));
      idle(3);
    end
    chk("t9_sat_br_w4", 32'(brc_b), 15); chk("t9_sat_mp_w4", 32'(mpc_b), 15);
    chk("t9_br_full", brc_a, 21); chk("t9_mp_full", mpc_a, 20);

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
